// File: rtl/acc_ctrl.sv
// Accumulator-array controller: sums K partial-sum tiles row by row into an external array, then drains it.
// Define ACC_CTRL_SAT_EN to make each lane sum saturate instead of wrapping.

module acc_ctrl_lane #(
    parameter int LANE_WIDTH = 24
) (
    input  logic [LANE_WIDTH-1:0] a_i,
    input  logic [LANE_WIDTH-1:0] b_i,
    output logic [LANE_WIDTH-1:0] sum_o
);
`ifdef ACC_CTRL_SAT_EN
    logic [LANE_WIDTH-1:0] raw;
    logic                  ovf;

    assign raw = a_i + b_i;
    // Overflow only when both operands share a sign and the result flips it.
    assign ovf = (a_i[LANE_WIDTH-1] == b_i[LANE_WIDTH-1]) && (raw[LANE_WIDTH-1] != a_i[LANE_WIDTH-1]);

    always_comb begin
        sum_o = raw;
        if (ovf) sum_o = a_i[LANE_WIDTH-1] ? {1'b1, {(LANE_WIDTH-1){1'b0}}}
                                           : {1'b0, {(LANE_WIDTH-1){1'b1}}};
    end
`else
    assign sum_o = a_i + b_i;
`endif
endmodule

module acc_ctrl #(
    parameter  int VEC_WIDTH  = 384,
    parameter  int LANE_WIDTH = 24,
    parameter  int ARR_DEPTH  = 16,
    localparam int ADDR_WIDTH = $clog2(ARR_DEPTH),
    localparam int NUM_LANES  = VEC_WIDTH / LANE_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [7:0]            i_num_k,
    output logic                  o_busy,
    output logic                  o_done,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [VEC_WIDTH-1:0]  i_in_data,
    output logic                  o_acc_we,
    output logic [ADDR_WIDTH-1:0] o_acc_addr_wr,
    output logic [VEC_WIDTH-1:0]  o_acc_data_wr,
    output logic [ADDR_WIDTH-1:0] o_acc_addr_rd,
    input  logic [VEC_WIDTH-1:0]  i_acc_data_rd,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [VEC_WIDTH-1:0]  o_out_data
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic [7:0]            tile_q, tile_d;
    logic [7:0]            num_k_q, num_k_d;
    logic                  row_last, tile_last;

    logic [NUM_LANES-1:0][LANE_WIDTH-1:0] rd_lanes, in_lanes, sum_lanes;

    assign rd_lanes = i_acc_data_rd;
    assign in_lanes = i_in_data;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        acc_ctrl_lane #(.LANE_WIDTH(LANE_WIDTH)) u_lane (
            .a_i  (rd_lanes[l]),
            .b_i  (in_lanes[l]),
            .sum_o(sum_lanes[l])
        );
    end

    assign row_last  = (row_q == ADDR_WIDTH'(ARR_DEPTH - 1));
    assign tile_last = (tile_q == num_k_q - 8'd1);

    // Both array ports follow the row counter; the read is combinational so
    // the read-modify-write of a row finishes on the edge that accepts its beat.
    assign o_acc_addr_rd = row_q;
    assign o_acc_addr_wr = row_q;
    assign o_acc_data_wr = (tile_q == 8'd0) ? i_in_data : sum_lanes;
    assign o_out_data    = i_acc_data_rd;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            tile_q  <= '0;
            num_k_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            tile_q  <= tile_d;
            num_k_q <= num_k_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        tile_d      = tile_q;
        num_k_d     = num_k_q;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_in_ready  = 1'b0;
        o_acc_we    = 1'b0;
        o_out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start && (i_num_k != 8'd0)) begin
                    num_k_d = i_num_k;
                    row_d   = '0;
                    tile_d  = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                o_busy     = 1'b1;
                o_in_ready = 1'b1;
                o_acc_we   = i_in_valid;
                if (i_in_valid) begin
                    row_d = row_last ? '0 : row_q + 1'b1;
                    if (row_last) begin
                        tile_d = tile_q + 8'd1;
                        if (tile_last) state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                o_busy      = 1'b1;
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    row_d = row_last ? '0 : row_q + 1'b1;
                    if (row_last) state_d = DONE;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_acc_ctrl.sv
// Scoreboard bench for acc_ctrl with a behavioural accumulator array; honours ACC_CTRL_SAT_EN.
`timescale 1ns/1ps
module tb_acc_ctrl;
    localparam int VEC = 384;
    localparam int LW  = 24;
    localparam int NL  = VEC / LW;
    localparam int DEP = 16;
    localparam int AW  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_start = 1'b0;
    logic [7:0]     i_num_k = '0;
    logic           o_busy, o_done;
    logic           i_in_valid = 1'b0;
    logic           o_in_ready;
    logic [VEC-1:0] i_in_data = '0;
    logic           o_acc_we;
    logic [AW-1:0]  o_acc_addr_wr, o_acc_addr_rd;
    logic [VEC-1:0] o_acc_data_wr, i_acc_data_rd;
    logic           o_out_valid;
    logic           i_out_ready = 1'b0;
    logic [VEC-1:0] o_out_data;

    acc_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_num_k(i_num_k),
        .o_busy(o_busy), .o_done(o_done),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
        .o_acc_we(o_acc_we), .o_acc_addr_wr(o_acc_addr_wr), .o_acc_data_wr(o_acc_data_wr),
        .o_acc_addr_rd(o_acc_addr_rd), .i_acc_data_rd(i_acc_data_rd),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data)
    );

    always #5 clk = ~clk;

    logic [VEC-1:0] mem [DEP];
    assign i_acc_data_rd = mem[o_acc_addr_rd];
    always @(posedge clk) if (o_acc_we) mem[o_acc_addr_wr] <= o_acc_data_wr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt, done_cyc, hs_cyc, accum_cyc, we_cnt;
    logic [VEC-1:0] exp_q [$];
    logic [VEC-1:0] stim [4][DEP];
    logic           prev_stall = 1'b0;
    logic [VEC-1:0] prev_data;

    task automatic chk(input string tag, input logic [VEC-1:0] got, input logic [VEC-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [VEC-1:0] fill(input int x);
        logic [VEC-1:0] v;
        for (int l = 0; l < NL; l++) v[l*LW +: LW] = LW'(x);
        return v;
    endfunction

    function automatic logic [VEC-1:0] vadd(input logic [VEC-1:0] a, input logic [VEC-1:0] b);
        logic [VEC-1:0] r;
        longint sa, sb, s, mx;
        mx = (longint'(1) << (LW - 1));
        for (int l = 0; l < NL; l++) begin
            sa = longint'($signed(a[l*LW +: LW]));
            sb = longint'($signed(b[l*LW +: LW]));
            s  = sa + sb;
`ifdef ACC_CTRL_SAT_EN
            if (s > mx - 1) s = mx - 1;
            else if (s < -mx) s = -mx;
`endif
            r[l*LW +: LW] = s[LW-1:0];
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: scoreboard pop on handshake, stall stability, event counters.
    always @(negedge clk) begin
        if (prev_stall) begin
            chk("stall_valid", o_out_valid, 1);
            chk("stall_data", o_out_data, prev_data);
        end
        prev_stall = o_out_valid && !i_out_ready;
        prev_data  = o_out_data;
        if (o_out_valid && i_out_ready) begin
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("drain_row", o_out_data, exp_q.pop_front());
            hs_cyc = cyc;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (o_in_ready) accum_cyc++;
        if (o_acc_we) we_cnt++;
    end

    task automatic start_job(input int nk);
        @(posedge clk); #1;
        i_start = 1'b1;
        i_num_k = 8'(nk);
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic feed_beat(input int t, input int r, input bit gaps, input bit poke);
        if (gaps) repeat ($urandom_range(0, 2)) begin
            i_in_valid = 1'b0;
            @(posedge clk); #1;
        end
        if (r == 0) chk("in_ready", o_in_ready, 1);
        i_in_valid = 1'b1;
        i_in_data  = stim[t][r];
        if (poke && t == 0 && r == 3) begin
            i_start = 1'b1;
            i_num_k = 8'd5;
        end
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic run_job(input int nk, input bit gaps, input bit stalls, input bit poke);
        int n;
        done_cnt  = 0;
        accum_cyc = 0;
        start_job(nk);
        chk("busy_start", o_busy, 1);
        for (int t = 0; t < nk; t++)
            for (int r = 0; r < DEP; r++) feed_beat(t, r, gaps, poke);
        i_in_valid = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            i_out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        i_out_ready = 1'b0;
        chk("drain_bound", n < 2000, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_cnt, 1);
        chk("done_lat", done_cyc - hs_cyc, 1);
        chk("idle_after", o_busy, 0);
    endtask

    initial begin
        logic [VEC-1:0] e, v;
        int snap;
        for (int i = 0; i < DEP; i++) mem[i] = '0;
        we_cnt = 0;
        #3;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_in_ready", o_in_ready, 0);
        chk("rst_we", o_acc_we, 0);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_addr_rd", o_acc_addr_rd, 0);
        chk("rst_addr_wr", o_acc_addr_wr, 0);
        #10 rst_n = 1'b1;

        // num_k=1, every lane of row r equals r
        for (int r = 0; r < DEP; r++) begin
            stim[0][r] = fill(r);
            exp_q.push_back(fill(r));
        end
        run_job(1, 0, 0, 0);

        // num_k=3, all lanes 5 on every tile
        for (int t = 0; t < 3; t++) for (int r = 0; r < DEP; r++) stim[t][r] = fill(5);
        for (int r = 0; r < DEP; r++) exp_q.push_back(fill(15));
        run_job(3, 0, 0, 0);
        chk("accum_len", accum_cyc, 48);

        // random data: gap-free, then with valid gaps and ready stalls
        for (int t = 0; t < 3; t++) for (int r = 0; r < DEP; r++)
            for (int l = 0; l < NL; l++) stim[t][r][l*LW +: LW] = LW'($urandom());
        for (int pass = 0; pass < 2; pass++) begin
            for (int r = 0; r < DEP; r++) begin
                e = stim[0][r];
                for (int t = 1; t < 3; t++) e = vadd(e, stim[t][r]);
                exp_q.push_back(e);
            end
            run_job(3, pass == 1, pass == 1, 0);
        end

        // lane0 overflow boundary, lane1 must not see a carry
        v = '0;
        v[23:0]  = 24'h7FFFFF;
        v[47:24] = 24'h000001;
        e = '0;
`ifdef ACC_CTRL_SAT_EN
        e[23:0] = 24'h7FFFFF;
`else
        e[23:0] = 24'hFFFFFE;
`endif
        e[47:24] = 24'h000002;
        for (int r = 0; r < DEP; r++) begin
            stim[0][r] = v;
            stim[1][r] = v;
            exp_q.push_back(e);
        end
        run_job(2, 0, 0, 0);

        // start with num_k=0 is ignored
        start_job(0);
        @(posedge clk); #1;
        chk("k0_busy", o_busy, 0);
        chk("k0_in_ready", o_in_ready, 0);

        // start during ACCUM is ignored
        for (int r = 0; r < DEP; r++) begin
            stim[0][r] = fill(r + 1);
            stim[1][r] = fill(2 * r);
            exp_q.push_back(fill(3 * r + 1));
        end
        run_job(2, 0, 0, 1);

        // reset at row 7 of tile 1
        start_job(2);
        for (int t = 0; t < 2; t++)
            for (int r = 0; r < DEP; r++)
                if (t == 0 || r < 7) feed_beat(t, r, 0, 0);
        i_in_valid = 1'b1;
        chk("pre_rst_row", o_acc_addr_wr, 7);
        chk("pre_rst_we", o_acc_we, 1);
        #2 rst_n = 1'b0;
        #1;
        snap = we_cnt;
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_we", o_acc_we, 0);
        chk("mid_rst_in_ready", o_in_ready, 0);
        chk("mid_rst_addr_wr", o_acc_addr_wr, 0);
        chk("mid_rst_addr_rd", o_acc_addr_rd, 0);
        chk("mid_rst_out_valid", o_out_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_no_we", we_cnt - snap, 0);
        chk("post_rst_busy", o_busy, 0);
        i_in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
